// File: rtl/store_pkg.sv
// Shared definitions for the store path: store-type encodings, FSM states
// and the widths of the lane-select fields taken from the byte address.
package store_pkg;

  localparam int WORD_W     = 32;
  localparam int LANE_SEL_W = 2;
  localparam int HALF_SEL_W = 1;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_INV = 2'b11
  } store_type_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } store_state_e;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane merge: overlays the new store data onto the old memory
// word in the lanes selected by the store type and low address bits.
// Shared with the load-side verification model, so it has no state.
module byte_lane_merge
  import store_pkg::*;
(
  input  logic [WORD_W-1:0]     old_word,
  input  logic [WORD_W-1:0]     new_data,
  input  store_type_e           store_type,
  input  logic [LANE_SEL_W-1:0] addr,
  output logic [WORD_W-1:0]     merged
);

  // Start from the old word and replace only the lanes being stored.
  always_comb begin
    merged = old_word;
    case (store_type)
      ST_SW: merged = new_data;
      ST_SH: begin
        if (addr[1]) merged[31:16] = new_data[15:0];
        else         merged[15:0]  = new_data[15:0];
      end
      ST_SB: merged[{addr, 3'b000} +: 8] = new_data[7:0];
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_size_unit.sv
// Store sequencer for SW/SH/SB. Full-word stores are written directly;
// halfword and byte stores read the containing word, merge, and write back.
// All outputs are registered from next-state values so they line up with
// the state they describe.
module store_size_unit #(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        store_type,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import store_pkg::*;

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  store_state_e      state_q, state_d;
  store_type_e       type_q, type_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] old_word_q, old_word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] merged;

  // Merge uses next-state request and old word so the write data is ready
  // in the same cycle the FSM enters WRITE.
  byte_lane_merge u_merge (
    .old_word   (old_word_d),
    .new_data   (wdata_d),
    .store_type (type_d),
    .addr       (addr_d[1:0]),
    .merged     (merged)
  );

  // Next-state logic: request latching, read-latency countdown and capture.
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    old_word_d = old_word_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          type_d  = store_type_e'(store_type);
          addr_d  = addr;
          wdata_d = wdata_b;
          case (store_type_e'(store_type))
            ST_SW: state_d = WRITE;
            ST_SH: begin
              if (addr[0]) begin
                state_d = ERR;
              end else begin
                state_d = READ;
                cnt_d   = CNT_W'(READ_LATENCY);
              end
            end
            ST_SB: begin
              state_d = READ;
              cnt_d   = CNT_W'(READ_LATENCY);
            end
            default: state_d = ERR;
          endcase
        end
      end
      READ: begin
        if (cnt_q <= CNT_W'(1)) begin
          old_word_d = mem_rdata;
          cnt_d      = '0;
          state_d    = WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latches and registered outputs; reset abandons any store.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      type_q     <= ST_SW;
      addr_q     <= '0;
      wdata_q    <= '0;
      old_word_q <= '0;
      cnt_q      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      old_word_q <= old_word_d;
      cnt_q      <= cnt_d;
      mem_addr   <= {addr_d[DATA_W-1:2], 2'b00};
      mem_wdata  <= merged;
      mem_wr     <= (state_d == WRITE);
      busy       <= (state_d != IDLE);
      done       <= (state_d == DONE) || (state_d == ERR);
      err        <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_store_size_unit.sv
// Self-checking bench for store_size_unit. Two instances cover
// READ_LATENCY=1 and READ_LATENCY=3; a byte-array reference model predicts
// the written word and the cycle timing of each request.
module tb_store_size_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [1:0]  stType;
  logic [31:0] stAddr, stWdata;
  logic [31:0] rdata0, rdata1;

  logic [31:0] memAddr0, memWdata0, memAddr1, memWdata1;
  logic        memWr0, busy0, done0, err0;
  logic        memWr1, busy1, done1, err1;

  int passCount = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  store_size_unit #(.DATA_W(32), .READ_LATENCY(1)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .store_type(stType),
    .addr(stAddr), .wdata_b(stWdata), .mem_rdata(rdata0),
    .mem_addr(memAddr0), .mem_wdata(memWdata0), .mem_wr(memWr0),
    .busy(busy0), .done(done0), .err(err0)
  );

  store_size_unit #(.DATA_W(32), .READ_LATENCY(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .store_type(stType),
    .addr(stAddr), .wdata_b(stWdata), .mem_rdata(rdata1),
    .mem_addr(memAddr1), .mem_wdata(memWdata1), .mem_wr(memWr1),
    .busy(busy1), .done(done1), .err(err1)
  );

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Reference merge: treat words as little-endian byte arrays.
  function automatic logic [31:0] modelWord(input logic [1:0] ty, input logic [31:0] a,
                                            input logic [31:0] wd, input logic [31:0] old);
    logic [7:0] b[4];
    logic [7:0] n[4];
    int lane;
    for (int i = 0; i < 4; i++) begin
      b[i] = old[8*i +: 8];
      n[i] = wd[8*i +: 8];
    end
    lane = int'(a[1:0]);
    if (ty == 2'd0) begin
      for (int i = 0; i < 4; i++) b[i] = n[i];
    end else if (ty == 2'd1) begin
      lane = (lane / 2) * 2;
      b[lane] = n[0];
      b[lane + 1] = n[1];
    end else if (ty == 2'd2) begin
      b[lane] = n[0];
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Run one request on instance sel and compare against the model. The
  // response is watched for a fixed window so stray writes are caught.
  task automatic applyStimulus(input int sel, input logic [1:0] ty, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rEarly,
                               input logic [31:0] rLate, input int lateCycle,
                               input int busyCycle, input string tag);
    int lat, wrCount, wrCycle, doneCount, doneCycle;
    logic [31:0] wrAddr, wrData;
    logic errAtDone, cycle1Busy;
    logic isErr;
    int expWrCycle, expDoneCycle;
    logic ow, ob, od, oe;
    logic [31:0] oa, owd;

    lat = (sel == 0) ? 1 : 3;
    wrCount = 0; wrCycle = -1; doneCount = 0; doneCycle = -1;
    wrAddr = '0; wrData = '0; errAtDone = 1'b0; cycle1Busy = 1'b0;

    @(negedge clk);
    stType = ty; stAddr = a; stWdata = wd;
    if (sel == 0) begin rdata0 = rEarly; start0 = 1'b1; end
    else          begin rdata1 = rEarly; start1 = 1'b1; end

    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      ow  = (sel == 0) ? memWr0    : memWr1;
      ob  = (sel == 0) ? busy0     : busy1;
      od  = (sel == 0) ? done0     : done1;
      oe  = (sel == 0) ? err0      : err1;
      oa  = (sel == 0) ? memAddr0  : memAddr1;
      owd = (sel == 0) ? memWdata0 : memWdata1;
      if (k == 1) cycle1Busy = ob;
      if (ow) begin wrCount++; wrCycle = k; wrAddr = oa; wrData = owd; end
      if (od) begin doneCount++; doneCycle = k; errAtDone = oe; end
      start0 = 1'b0; start1 = 1'b0;
      if (k == busyCycle) begin
        stType = 2'd0; stAddr = 32'h0000_0F00; stWdata = 32'h5555_AAAA;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      end
      if (k == lateCycle) begin
        if (sel == 0) rdata0 = rLate; else rdata1 = rLate;
      end
    end

    isErr = (ty == 2'd3) || (ty == 2'd1 && a[0]);
    expWrCycle = (ty == 2'd0) ? 1 : 1 + lat;
    expDoneCycle = isErr ? 1 : expWrCycle + 1;

    checkOutput({tag, ".busy1"}, 32'(cycle1Busy), 32'd1);
    checkOutput({tag, ".wrCount"}, wrCount, isErr ? 0 : 1);
    if (!isErr) begin
      checkOutput({tag, ".wrCycle"}, wrCycle, expWrCycle);
      checkOutput({tag, ".wrAddr"}, wrAddr, {a[31:2], 2'b00});
      checkOutput({tag, ".wrData"}, wrData, modelWord(ty, a, wd, rLate));
    end
    checkOutput({tag, ".doneCount"}, doneCount, 1);
    checkOutput({tag, ".doneCycle"}, doneCycle, expDoneCycle);
    checkOutput({tag, ".err"}, 32'(errAtDone), 32'(isErr));
  endtask

  initial begin
    logic [1:0]  rTy;
    logic [31:0] rA, rWd, rOld;
    int wrSeen;

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    stType = '0; stAddr = '0; stWdata = '0; rdata0 = '0; rdata1 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset.memWr0", 32'(memWr0), 32'd0);
    checkOutput("reset.busy0", 32'(busy0), 32'd0);
    checkOutput("reset.done0", 32'(done0), 32'd0);
    checkOutput("reset.err0", 32'(err0), 32'd0);
    checkOutput("reset.memAddr0", memAddr0, 32'd0);
    checkOutput("reset.memWdata0", memWdata0, 32'd0);
    checkOutput("reset.busy1", 32'(busy1), 32'd0);
    checkOutput("reset.memWr1", 32'(memWr1), 32'd0);
    reset = 1'b0;

    $display("[TB] directed stores");
    applyStimulus(0, 2'd0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0, "sw");
    applyStimulus(0, 2'd2, 32'h0000_0102, 32'hFFFF_FFAB, 32'h1122_3344, 32'h1122_3344, 0, 0, "sbLane2");
    applyStimulus(0, 2'd1, 32'h0000_0202, 32'h0000_1234, 32'hCAFE_BABE, 32'hCAFE_BABE, 0, 0, "shUpper");
    applyStimulus(0, 2'd1, 32'h0000_0203, 32'h0000_1234, 32'hCAFE_BABE, 32'hCAFE_BABE, 0, 0, "shMisaligned");
    applyStimulus(0, 2'd3, 32'h0000_0100, 32'h1234_5678, 32'hCAFE_BABE, 32'hCAFE_BABE, 0, 0, "invalidType");
    applyStimulus(0, 2'd2, 32'hFFFF_FFFF, 32'h0000_0077, 32'h0102_0304, 32'h0102_0304, 0, 0, "sbWrap");
    applyStimulus(1, 2'd2, 32'h0000_0007, 32'h0000_00EE, 32'hAAAA_AAAA, 32'h0102_0304, 3, 0, "lat3Late");
    applyStimulus(1, 2'd2, 32'h0000_0301, 32'h0000_0099, 32'h8877_6655, 32'h8877_6655, 0, 2, "busyStart");
    applyStimulus(0, 2'd1, 32'h0000_0400, 32'h9999_ABCD, 32'h1111_2222, 32'h1111_2222, 0, 1, "busyStart0");

    $display("[TB] reset during read");
    @(negedge clk);
    stType = 2'd2; stAddr = 32'h0000_0506; stWdata = 32'h0000_00CC; rdata0 = 32'h1357_9BDF;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checkOutput("rstRead.busyBefore", 32'(busy0), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstRead.memWr", 32'(memWr0), 32'd0);
    checkOutput("rstRead.busy", 32'(busy0), 32'd0);
    checkOutput("rstRead.done", 32'(done0), 32'd0);
    checkOutput("rstRead.err", 32'(err0), 32'd0);
    checkOutput("rstRead.memAddr", memAddr0, 32'd0);
    checkOutput("rstRead.memWdata", memWdata0, 32'd0);
    reset = 1'b0;
    wrSeen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (memWr0 || busy0 || done0) wrSeen++;
    end
    checkOutput("rstRead.quiet", wrSeen, 0);
    applyStimulus(0, 2'd0, 32'h0000_0010, 32'h0BAD_F00D, 32'h0, 32'h0, 0, 0, "afterReset");

    $display("[TB] random stores");
    for (int i = 0; i < 24; i++) begin
      rTy  = 2'($urandom_range(0, 3));
      rA   = $urandom;
      rWd  = $urandom;
      rOld = $urandom;
      applyStimulus(i % 2, rTy, rA, rWd, rOld, rOld, 0, 0, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/store_size_unit.md
Name: store_size_unit

Overview:
- Memory-write counterpart of the register write-back path: takes register B data plus an effective address and performs SW/SH/SB stores to the byte-addressed, word-ported data memory.
- SW is a direct word write. SH and SB do read-modify-write: read the containing word, merge the new lanes, write the word back.
- Sits between the multicycle control unit (start/done handshake) and the memory port mux.
- Little-endian lanes: byte 0 is bits [7:0].

Parameters:
- DATA_W, 32, memory and register data width (fixed at 32; only this value is supported).
- READ_LATENCY, 1, cycles from read address presented to mem_rdata valid; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle store request from the control unit; sampled only in IDLE.
- store_type  in  2  00=SW, 01=SH, 10=SB, 11=invalid.
- addr  in  32  effective byte address (ALUOut); sampled with start.
- wdata_b  in  32  register B value; sampled with start.
- mem_rdata  in  32  memory read data.
- mem_addr  out  32  word address = {addr_latched[31:2], 2'b00}.
- mem_wdata  out  32  merged word to write.
- mem_wr  out  1  memory write strobe, high exactly one cycle per completed store.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse at store completion, also pulsed on error.
- err  out  1  one-cycle pulse together with done when the request was rejected.

Behaviour:
- All outputs are registered. Reset values: mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, err=0, state=IDLE, read counter=0.
- Reset has priority in any state. A store in progress is abandoned and no write is issued after reset.
- IDLE:
  - When start=1, latch store_type, addr and wdata_b.
  - SW goes to WRITE.
  - SH with addr[0]=0 goes to READ; SB goes to READ.
  - SH with addr[0]=1, or store_type=11, goes to ERR.
- start while busy=1 is ignored and not queued.
- READ:
  - mem_addr is driven with the word address and mem_wr=0.
  - Stay READ_LATENCY cycles, counted by a down-counter.
  - On the edge ending the last READ cycle, capture mem_rdata into old_word, then go to WRITE.
- WRITE:
  - mem_wr=1 for one cycle; mem_addr holds; mem_wdata holds the merged word.
  - Next state is DONE.
- Merge rules:
  - SW: mem_wdata = wdata_b.
  - SH: the lane pair selected by addr[1] gets wdata_b[15:0]. addr[1]=0 writes bits [15:0]; addr[1]=1 writes bits [31:16]. The other 16 bits come from old_word.
  - SB: byte lane addr[1:0] gets wdata_b[7:0]. The other three bytes come from old_word.
- DONE: done=1 for one cycle, then IDLE. A new start is accepted in the cycle after DONE.
- ERR: done=1 and err=1 for one cycle, mem_wr stays 0, then IDLE.
- Latency from the start cycle, with the start-sampling edge counted as edge 0:
  - SW: mem_wr in cycle 1, done in cycle 2.
  - SH/SB: mem_wr in cycle 1+READ_LATENCY, done in cycle 2+READ_LATENCY.
- Address wrap: addr=0xFFFFFFFF (SB) gives word 0xFFFFFFFC, lane 3. There is no carry or overflow handling.
- Upper bits of wdata_b are ignored for SH/SB. No sign or zero extension is applied on the store side.

Decomposition:
- Shared package store_pkg holds:
  - store_type encodings ST_SW, ST_SH, ST_SB, ST_INV.
  - state encoding IDLE, READ, WRITE, DONE, ERR (3 bits).
  - the lane-select constant widths.
- One combinational sub-module, byte_lane_merge, with inputs old_word, new_data, store_type, addr[1:0] and output merged.
  - It is reused by the load-side verification model.
- The FSM, counter and latches stay in store_size_unit.

Test Plan:
- SW: reset, then start with store_type=00, addr=0x00000104, wdata_b=0xDEADBEEF.
  - Expect mem_wr=1 in cycle 1 with mem_addr=0x00000104 and mem_wdata=0xDEADBEEF.
  - Expect done in cycle 2, err=0, and no read cycle.
- SB, lane 2: mem_rdata=0x11223344, start SB with addr=0x00000102 and wdata_b=0xFFFFFFAB, READ_LATENCY=1.
  - Expect READ in cycle 1, mem_wr in cycle 2 with mem_wdata=0x11AB3344, done in cycle 3.
- SH, upper half: mem_rdata=0xCAFEBABE, start SH with addr=0x00000202 and wdata_b=0x00001234.
  - Expect mem_wdata=0x1234BABE and mem_addr=0x00000200.
- Errors:
  - SH with addr=0x00000203 gives done=1 and err=1 in cycle 1, and mem_wr never asserts.
  - store_type=11 behaves the same way.
- Reset and start-while-busy:
  - Assert reset during the READ of an SB. Expect mem_wr to stay 0, all outputs 0 on the next cycle, and state IDLE.
  - Pulse start while busy. Expect it to be ignored, with exactly one mem_wr per accepted request.
- READ_LATENCY=3 with SB, addr=0x00000007, wdata_b=0x000000EE, and mem_rdata changing to 0x01020304 only in the third read cycle.
  - Expect mem_wdata=0xEE020304 and mem_wr in cycle 4.
